key_entry_controller: RTL and testbench
=======================================

# key_entry_controller

Sequencing controller between the keyboard scanner and the charge controller. It turns the scanner's held key strobes into single-cycle events and accumulates a two-digit BCD charge amount. It tracks coin credit and arms and launches a charge session only when the amount is confirmed and paid for. It runs on the same 1 kHz divided clock as the scanner.

## Interface
- MAX_AMOUNT, 20: largest amount accepted on confirm, in yuan (1..99).
- TIMEOUT_CYC, 10000: idle cycles in ENTRY/ARMED before abandoning entry (10 s at 1 kHz).
- CREDIT_MAX, 99: credit saturation value.
- clk  in  1  1 kHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_value  in  4  digit code from scanner, valid while press_num high.
- press_num  in  1  level: number key held.
- start  in  1  level: START key held.
- clear  in  1  level: CLEAR key held.
- confirm  in  1  level: CONFIRM key held.
- coin_pulse  in  1  one-cycle pulse per 1-yuan coin.
- charge_done  in  1  one-cycle pulse from the charge controller when the session ends.
- amount_bcd  out  8  entered amount, {tens, ones} BCD.
- credit  out  7  paid credit, binary.
- armed  out  1  amount confirmed, waiting for START.
- charge_en  out  1  high for the whole charge session.
- charge_amount  out  7  binary amount of the running session.
- err  out  1  one-cycle pulse on a rejected action.

## Operation
- Key inputs are levels held for the duration of a press. Each input is rising-edge detected against a registered copy. One press produces exactly one event.
- Event priority within a cycle: clear > confirm > start > digit. Only the highest-priority event is acted on. The rest are dropped.
- The states are IDLE, ENTRY, ARMED and CHARGING.
- IDLE:
  - A digit event loads amount_bcd = {0, d} and moves to ENTRY.
  - confirm and start raise err.
  - clear is a no-op.
- ENTRY:
  - Digit event with tens = 0: amount_bcd <= {ones, d}.
  - Digit event with tens != 0 (two digits already entered): ignored, raises err.
  - confirm with amount = 0 or amount > MAX_AMOUNT raises err, clears amount_bcd to 0 and stays in ENTRY.
  - confirm otherwise moves to ARMED.
  - start raises err.
  - clear zeroes the amount and moves to IDLE.
- ARMED:
  - start with credit >= amount: credit <= credit − amount, charge_amount <= amount, charge_en = 1, move to CHARGING.
  - start with credit < amount raises err and stays in ARMED.
  - Digits and confirm are ignored.
  - clear moves to IDLE with amount 0.
- CHARGING:
  - charge_done, or a clear event (abort), drops charge_en and moves to IDLE. amount_bcd and charge_amount are cleared.
  - All other key events are ignored.
- Credit:
  - Credit increments on coin_pulse in every state and saturates at CREDIT_MAX.
  - A coin arriving in the same cycle as a successful start is added after the subtraction.
  - Credit is never cleared except by reset.
- armed = (state == ARMED).
- Amount arithmetic is binary: tens×10 + ones, computed combinationally from amount_bcd.

## Timing
- Reset values: state IDLE, amount_bcd 0, credit 0, armed 0, charge_en 0, charge_amount 0, err 0, edge registers 0.
- Input latency: a key input first sampled high at edge N (previous sample low) updates state and outputs at edge N. Results are visible in the cycle after edge N. err is high for exactly that cycle.
- A key held across many cycles is one event. Releasing and re-pressing produces a new event.
- A key already high when rst_n deasserts produces no event until it is released and pressed again.
- charge_en rises at the accepting start edge. It falls at the edge that samples charge_done or the clear event.
- Reset asserted mid-session drops charge_en immediately (asynchronously).

## Configuration
- KEY_ENTRY_TIMEOUT_EN defined:
  - A 14-bit counter runs in ENTRY and ARMED.
  - It is cleared on any accepted key event and on every state change.
  - When it reaches TIMEOUT_CYC−1 with no event in that cycle, the block moves to IDLE and amount_bcd is cleared. Credit is kept and err is not raised.
  - Any key event arriving in that same cycle takes precedence and cancels the timeout.
- KEY_ENTRY_TIMEOUT_EN undefined: there is no counter, and ENTRY and ARMED wait indefinitely.

## Structure
- key_entry_pkg holds:
  - state encoding constants (IDLE = 2'd0, ENTRY = 2'd1, ARMED = 2'd2, CHARGING = 2'd3);
  - defaults for MAX_AMOUNT, TIMEOUT_CYC and CREDIT_MAX;
  - the BCD-to-binary width (7).
- Sub-module key_edge_detect: a 4-bit registered rising-edge detector covering press_num, start, clear and confirm, with async active-low reset. It is instantiated once.

## Test plan
- Press 1, release, press 5, confirm, 3 coins, start → err pulse at start. Then 12 more coins (credit 15), start → charge_en = 1, charge_amount = 15, credit = 0.
- Press 2, 5, confirm → err pulse, amount_bcd = 8'h00, still ENTRY (25 > MAX_AMOUNT).
- Press 1, 2, 3 → third digit gives an err pulse, amount_bcd stays 8'h12. Hold 5 for 40 cycles → exactly one accepted digit event after re-entry.
- Press clear and confirm rising together in ARMED → IDLE, amount 0, no err. During CHARGING, clear → charge_en falls next edge, credit unchanged.
- 105 coin pulses → credit saturates at 99.
- With KEY_ENTRY_TIMEOUT_EN, enter 7 and wait 10000 cycles → IDLE, amount 0, credit kept. A key event on cycle 9999 keeps the block in ENTRY.

Source files
------------

// File: rtl/key_entry_pkg.sv
// Shared types and defaults for the key entry controller.
// Timeout build option: KEY_ENTRY_TIMEOUT_EN.
package key_entry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        ARMED    = 2'd2,
        CHARGING = 2'd3
    } state_t;

    localparam int MAX_AMOUNT_DEF  = 20;
    localparam int TIMEOUT_CYC_DEF = 10000;
    localparam int CREDIT_MAX_DEF  = 99;
    localparam int BIN_W           = 7;
    localparam int TO_W            = 14;

    // Bit positions in the edge detector's key vector
    localparam int KEY_NUM     = 0;
    localparam int KEY_START   = 1;
    localparam int KEY_CLEAR   = 2;
    localparam int KEY_CONFIRM = 3;

    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [7:0] bcd);
        logic [BIN_W-1:0] tens;
        logic [BIN_W-1:0] ones;
        tens = BIN_W'(bcd[7:4]);
        ones = BIN_W'(bcd[3:0]);
        return tens * BIN_W'(10) + ones;
    endfunction

endpackage

// File: rtl/key_entry_controller_if.sv
// Key, coin and session signals between scanner/charger side and the controller.
interface key_entry_controller_if;
    import key_entry_pkg::*;

    logic [3:0]       key_value;
    logic             press_num;
    logic             start;
    logic             clear;
    logic             confirm;
    logic             coin_pulse;
    logic             charge_done;
    logic [7:0]       amount_bcd;
    logic [BIN_W-1:0] credit;
    logic             armed;
    logic             charge_en;
    logic [BIN_W-1:0] charge_amount;
    logic             err;

    modport master (
        output key_value, press_num, start, clear, confirm, coin_pulse, charge_done,
        input  amount_bcd, credit, armed, charge_en, charge_amount, err
    );

    modport slave (
        input  key_value, press_num, start, clear, confirm, coin_pulse, charge_done,
        output amount_bcd, credit, armed, charge_en, charge_amount, err
    );

endinterface

// File: rtl/key_edge_detect.sv
// Registered rising-edge detector for the four key levels.
// Keys already held when reset releases are swallowed until released and re-pressed.
module key_edge_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] level,
    output logic [3:0] rise
);

    logic [3:0] prev;
    logic       primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= 4'd0;
            primed <= 1'b0;
        end else begin
            prev   <= level;
            primed <= 1'b1;
        end
    end

    assign rise = level & ~prev & {4{primed}};

endmodule

// File: rtl/key_entry_controller.sv
// Amount entry, coin credit and charge session sequencing; key events act at the sampling edge.
// Optional idle timeout in ENTRY/ARMED enabled by KEY_ENTRY_TIMEOUT_EN.
module key_entry_controller
    import key_entry_pkg::*;
#(
    parameter int MAX_AMOUNT  = MAX_AMOUNT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CREDIT_MAX  = CREDIT_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    key_entry_controller_if.slave  bus
);

    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_AMOUNT);
    localparam logic [BIN_W-1:0] CREDIT_B = BIN_W'(CREDIT_MAX);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << TO_W)) begin : g_bad_timeout_cyc
        $error("TIMEOUT_CYC out of range");
    end

    state_t           state;
    logic [7:0]       amount_bcd;
    logic [BIN_W-1:0] credit;
    logic             charge_en;
    logic [BIN_W-1:0] charge_amount;
    logic             err;

    logic [3:0]       rise;
    logic             ev_clear, ev_confirm, ev_start, ev_digit, any_ev;
    logic [BIN_W-1:0] amount_bin;
    logic             start_ok;
    logic [BIN_W-1:0] credit_base;
    logic [BIN_W-1:0] credit_next;
    logic             timeout;

    key_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({bus.confirm, bus.clear, bus.start, bus.press_num}),
        .rise  (rise)
    );

    // Only the highest-priority event of a cycle survives
    assign ev_clear   = rise[KEY_CLEAR];
    assign ev_confirm = rise[KEY_CONFIRM] & ~ev_clear;
    assign ev_start   = rise[KEY_START] & ~rise[KEY_CONFIRM] & ~ev_clear;
    assign ev_digit   = rise[KEY_NUM] & ~rise[KEY_START] & ~rise[KEY_CONFIRM] & ~ev_clear;
    assign any_ev     = |rise;

    assign amount_bin = bcd_to_bin(amount_bcd);
    assign start_ok   = (state == ARMED) && ev_start && (credit >= amount_bin);

    // Coin is applied after the start deduction
    always_comb begin
        credit_base = start_ok ? (credit - amount_bin) : credit;
        credit_next = credit_base;
        if (bus.coin_pulse && (credit_base < CREDIT_B)) begin
            credit_next = credit_base + BIN_W'(1);
        end
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] idle_cnt;
    logic            waiting;

    assign waiting = (state == ENTRY) || (state == ARMED);
    assign timeout = waiting && (idle_cnt == TO_LAST) && !any_ev;

    // Every exit from ENTRY/ARMED is an event or the timeout itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!waiting || any_ev || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            amount_bcd    <= 8'h00;
            credit        <= '0;
            charge_en     <= 1'b0;
            charge_amount <= '0;
            err           <= 1'b0;
        end else begin
            credit <= credit_next;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_clear) begin
                        state <= IDLE;
                    end else if (ev_confirm || ev_start) begin
                        err <= 1'b1;
                    end else if (ev_digit) begin
                        amount_bcd <= {4'd0, bus.key_value};
                        state      <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (ev_clear) begin
                        amount_bcd <= 8'h00;
                        state      <= IDLE;
                    end else if (ev_confirm) begin
                        if (amount_bin == '0 || amount_bin > MAX_B) begin
                            err        <= 1'b1;
                            amount_bcd <= 8'h00;
                        end else begin
                            state <= ARMED;
                        end
                    end else if (ev_start) begin
                        err <= 1'b1;
                    end else if (ev_digit) begin
                        if (amount_bcd[7:4] == 4'd0) begin
                            amount_bcd <= {amount_bcd[3:0], bus.key_value};
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (timeout) begin
                        amount_bcd <= 8'h00;
                        state      <= IDLE;
                    end
                end
                ARMED: begin
                    if (ev_clear) begin
                        amount_bcd <= 8'h00;
                        state      <= IDLE;
                    end else if (ev_start) begin
                        if (start_ok) begin
                            charge_en     <= 1'b1;
                            charge_amount <= amount_bin;
                            state         <= CHARGING;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (timeout) begin
                        amount_bcd <= 8'h00;
                        state      <= IDLE;
                    end
                end
                CHARGING: begin
                    if (bus.charge_done || ev_clear) begin
                        charge_en     <= 1'b0;
                        charge_amount <= '0;
                        amount_bcd    <= 8'h00;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.amount_bcd    = amount_bcd;
    assign bus.credit        = credit;
    assign bus.armed         = (state == ARMED);
    assign bus.charge_en     = charge_en;
    assign bus.charge_amount = charge_amount;
    assign bus.err           = err;

endmodule

// File: tb/tb_key_entry_controller.sv
// Directed scoreboard bench for key_entry_controller (timeout section under KEY_ENTRY_TIMEOUT_EN).
module tb_key_entry_controller;
    import key_entry_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_controller_if bus ();

    key_entry_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [7:0] amt;
        logic [6:0] cred;
        logic       armed;
        logic       en;
        logic [6:0] camt;
        logic       err;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } item_t;

    item_t exp_q[$];
    item_t mon_item;
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [7:0] e_amt   = 8'h00;
    logic [6:0] e_cred  = 7'd0;
    logic       e_armed = 1'b0;
    logic       e_en    = 1'b0;
    logic [6:0] e_camt  = 7'd0;

    function automatic obs_t sample();
        obs_t s;
        s.amt   = bus.amount_bcd;
        s.cred  = bus.credit;
        s.armed = bus.armed;
        s.en    = bus.charge_en;
        s.camt  = bus.charge_amount;
        s.err   = bus.err;
        return s;
    endfunction

    task automatic check(input string tag, input obs_t act, input obs_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got amt=%h cred=%0d armed=%b en=%b camt=%0d err=%b, want amt=%h cred=%0d armed=%b en=%b camt=%0d err=%b",
                     tag, act.amt, act.cred, act.armed, act.en, act.camt, act.err,
                     req.amt, req.cred, req.armed, req.en, req.camt, req.err);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 2 time units after the edge
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_item = exp_q.pop_front();
            check(mon_item.tag, sample(), mon_item.o);
        end
    end

    task automatic step(input string tag, input logic [3:0] kv, input logic pn, input logic st,
                        input logic cl, input logic cf, input logic coin, input logic done,
                        input logic e_err);
        item_t it;
        @(negedge clk);
        bus.key_value   = kv;
        bus.press_num   = pn;
        bus.start       = st;
        bus.clear       = cl;
        bus.confirm     = cf;
        bus.coin_pulse  = coin;
        bus.charge_done = done;
        @(posedge clk);
        it.o   = '{amt: e_amt, cred: e_cred, armed: e_armed, en: e_en, camt: e_camt, err: e_err};
        it.tag = tag;
        exp_q.push_back(it);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Press for one cycle, then release; expectations already reflect the press
    task automatic press(input string tag, input logic [3:0] kv, input logic pn, input logic st,
                         input logic cl, input logic cf, input logic e_err);
        step(tag, kv, pn, st, cl, cf, 0, 0, e_err);
        step({tag, "_rel"}, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic digit(input string tag, input logic [3:0] d, input logic e_err);
        press(tag, d, 1, 0, 0, 0, e_err);
    endtask

    task automatic coins(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (e_cred < 7'd99) e_cred = e_cred + 7'd1;
            step(tag, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
    endtask

    initial begin
        bus.key_value   = 4'd3;
        bus.press_num   = 1'b1;
        bus.start       = 1'b0;
        bus.clear       = 1'b0;
        bus.confirm     = 1'b0;
        bus.coin_pulse  = 1'b0;
        bus.charge_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Key held through reset release gives no event
        step("rst_held", 4'd3, 1, 0, 0, 0, 0, 0, 0);
        step("rst_held2", 4'd3, 1, 0, 0, 0, 0, 0, 0);
        step("rst_rel", 4'd0, 0, 0, 0, 0, 0, 0, 0);

        // 15 yuan: short on credit, then paid with a coin landing on the start edge
        e_amt = 8'h01; digit("d1", 4'd1, 0);
        e_amt = 8'h15; digit("d5", 4'd5, 0);
        e_armed = 1'b1; press("cf15", 0, 0, 0, 0, 1, 0);
        coins("coin3", 3);
        press("start_short", 0, 0, 1, 0, 0, 1);
        coins("coin12", 12);
        e_cred = 7'd1; e_en = 1'b1; e_camt = 7'd15; e_armed = 1'b0;
        step("start_ok", 4'd0, 0, 1, 0, 0, 1, 0, 0);
        step("start_rel", 4'd0, 0, 0, 0, 0, 0, 0, 0);
        digit("chg_digit_ignored", 4'd2, 0);
        press("chg_confirm_ignored", 0, 0, 0, 0, 1, 0);
        e_en = 1'b0; e_camt = 7'd0; e_amt = 8'h00;
        step("charge_done", 4'd0, 0, 0, 0, 0, 0, 1, 0);

        // IDLE rejections
        press("idle_confirm", 0, 0, 0, 0, 1, 1);
        press("idle_start", 0, 0, 1, 0, 0, 1);
        press("idle_clear", 0, 0, 0, 1, 0, 0);

        // 25 exceeds the limit; amount cleared, still in ENTRY
        e_amt = 8'h02; digit("d2", 4'd2, 0);
        e_amt = 8'h25; digit("d25", 4'd5, 0);
        e_amt = 8'h00; press("cf25", 0, 0, 0, 0, 1, 1);
        e_amt = 8'h01; digit("re_d1", 4'd1, 0);
        e_amt = 8'h12; digit("re_d2", 4'd2, 0);
        digit("third_digit", 4'd3, 1);

        // Held key is a single event
        e_amt = 8'h00; press("clear_entry", 0, 0, 0, 1, 0, 0);
        e_amt = 8'h05;
        for (int i = 0; i < 40; i++) step("hold5", 4'd5, 1, 0, 0, 0, 0, 0, 0);
        step("hold5_rel", 4'd0, 0, 0, 0, 0, 0, 0, 0);
        e_armed = 1'b1; press("cf5", 0, 0, 0, 0, 1, 0);
        press("start_low_credit", 0, 0, 1, 0, 0, 1);
        digit("armed_digit_ignored", 4'd7, 0);
        e_armed = 1'b0; e_amt = 8'h00;
        press("clear_confirm_armed", 0, 0, 0, 1, 1, 0);

        // Zero amount and exactly-MAX amount
        e_amt = 8'h00; digit("d0", 4'd0, 0);
        press("cf0", 0, 0, 0, 0, 1, 1);
        e_amt = 8'h02; digit("d2b", 4'd2, 0);
        e_amt = 8'h20; digit("d20", 4'd0, 0);
        e_armed = 1'b1; press("cf20", 0, 0, 0, 0, 1, 0);
        coins("coin19", 19);
        e_cred = 7'd0; e_en = 1'b1; e_camt = 7'd20; e_armed = 1'b0;
        press("start20", 0, 0, 1, 0, 0, 0);
        coins("coin_chg", 2);
        e_en = 1'b0; e_camt = 7'd0; e_amt = 8'h00;
        press("abort_clear", 0, 0, 0, 1, 0, 0);

        // One over the limit
        e_amt = 8'h02; digit("d2c", 4'd2, 0);
        e_amt = 8'h21; digit("d21", 4'd1, 0);
        e_amt = 8'h00; press("cf21", 0, 0, 0, 0, 1, 1);
        press("clear21", 0, 0, 0, 1, 0, 0);

        // Credit saturation
        coins("coin105", 105);
        e_amt = 8'h09; digit("d9", 4'd9, 0);
        e_armed = 1'b1; press("cf9", 0, 0, 0, 0, 1, 0);
        e_cred = 7'd90; e_en = 1'b1; e_camt = 7'd9; e_armed = 1'b0;
        press("start9", 0, 0, 1, 0, 0, 0);

        // Asynchronous reset mid-session
        drain();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", sample(), '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        e_amt = 8'h00; e_cred = 7'd0; e_armed = 1'b0; e_en = 1'b0; e_camt = 7'd0;
        idle("post_reset", 2);

`ifdef KEY_ENTRY_TIMEOUT_EN
        coins("to_coin", 3);
        e_amt = 8'h07; digit("to_d7", 4'd7, 0);
        idle("to_wait1", 9998);
        e_amt = 8'h73;
        step("to_cancel", 4'd3, 1, 0, 0, 0, 0, 0, 0);
        step("to_cancel_rel", 4'd0, 0, 0, 0, 0, 0, 0, 0);
        idle("to_wait2", 9998);
        e_amt = 8'h00;
        idle("to_expire", 1);
        e_amt = 8'h04; digit("to_after_d4", 4'd4, 0);
`endif

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
